// File: rtl/acc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : acc_mem_arbiter
// Description : Shares the accumulator processor's single-port memory between
//               instruction fetch (if), data load/store (dm) and I/O/debug
//               (io). Each access has a fixed WAIT_CYCLES+1 memory cycles and
//               is followed by a one-cycle done pulse with registered rdata.
//               Optional macro ACC_ARB_ROUND_ROBIN_EN selects round-robin
//               arbitration (if -> dm -> io); otherwise the priority is fixed
//               at dm > if > io.
// Revision    : 1.0 - initial release
// ============================================================================
module acc_mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_done,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [1:0]        grant_id,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Counter wide enough to hold WAIT_CYCLES, never narrower than one bit.
    localparam int               CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [1:0] ID_NONE = 2'd0;
    localparam logic [1:0] ID_IF   = 2'd1;
    localparam logic [1:0] ID_DM   = 2'd2;
    localparam logic [1:0] ID_IO   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        grant_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic              any_req;
    logic [1:0]        win;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign any_req = if_req | dm_req | io_req;

`ifdef ACC_ARB_ROUND_ROBIN_EN
    // Last winner; resets to io so that if is first in line after reset.
    logic [1:0] last_q;

    // Round-robin winner: search starts at the requester after the last winner.
    always_comb begin
        win = ID_NONE;
        case (last_q)
            ID_IF: begin
                if (dm_req)      win = ID_DM;
                else if (io_req) win = ID_IO;
                else if (if_req) win = ID_IF;
            end
            ID_DM: begin
                if (io_req)      win = ID_IO;
                else if (if_req) win = ID_IF;
                else if (dm_req) win = ID_DM;
            end
            default: begin
                if (if_req)      win = ID_IF;
                else if (dm_req) win = ID_DM;
                else if (io_req) win = ID_IO;
            end
        endcase
    end

    // Remember the winner each time an access is started.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= ID_IO;
        end else if (state_q == S_IDLE && any_req) begin
            last_q <= win;
        end
    end
`else
    // Fixed-priority winner: dm > if > io.
    always_comb begin
        win = ID_NONE;
        if (dm_req)      win = ID_DM;
        else if (if_req) win = ID_IF;
        else if (io_req) win = ID_IO;
    end
`endif

    // Select the winning requester's access attributes; fetches are always reads.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        case (win)
            ID_IF: begin
                sel_addr = if_addr;
            end
            ID_DM: begin
                sel_we    = dm_we;
                sel_addr  = dm_addr;
                sel_wdata = dm_wdata;
            end
            ID_IO: begin
                sel_we    = io_we;
                sel_addr  = io_addr;
                sel_wdata = io_wdata;
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> RESP -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (any_req) state_d = S_ACCESS;
            S_ACCESS: if (cnt_q == CNT_LAST) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Access datapath: latch the winner in IDLE, count wait states, capture read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            grant_q <= ID_NONE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        cnt_q   <= '0;
                        grant_q <= win;
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                    end
                end
                S_ACCESS: begin
                    if (cnt_q == CNT_LAST) begin
                        if (!we_q) rdata_q <= mem_rdata;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_RESP: begin
                    grant_q <= ID_NONE;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state and the latched access.
    always_comb begin
        mem_en    = (state_q == S_ACCESS);
        mem_we    = (state_q == S_ACCESS) && we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        busy      = (state_q != S_IDLE);
        grant_id  = grant_q;
        rdata     = rdata_q;
        if_done   = (state_q == S_RESP) && (grant_q == ID_IF);
        dm_done   = (state_q == S_RESP) && (grant_q == ID_DM);
        io_done   = (state_q == S_RESP) && (grant_q == ID_IO);
    end

endmodule
`default_nettype wire

// File: tb/tb_acc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_acc_mem_arbiter
// Description : Scoreboard bench for acc_mem_arbiter. Stimulus pushes the
//               expected {owner, rdata, done cycle} for each access; monitors
//               pop and compare on every done pulse. A second instance runs
//               with WAIT_CYCLES=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_mem_arbiter;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic tb_init;
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Main instance (WAIT_CYCLES = 2)
    logic        if_req, dm_req, dm_we, io_req, io_we;
    logic [15:0] if_addr, dm_addr, dm_wdata, io_addr, io_wdata;
    logic        if_done, dm_done, io_done, busy, mem_en, mem_we;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  grant_id;

    acc_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_done(dm_done),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata), .io_done(io_done),
        .rdata(rdata), .busy(busy), .grant_id(grant_id),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Second instance (WAIT_CYCLES = 0), only io is exercised
    logic        if2_req, dm2_req, dm2_we, io2_req, io2_we;
    logic [15:0] if2_addr, dm2_addr, dm2_wdata, io2_addr, io2_wdata;
    logic        if2_done, dm2_done, io2_done, busy2, mem2_en, mem2_we;
    logic [15:0] rdata2, mem2_addr, mem2_wdata, mem2_rdata;
    logic [1:0]  grant2_id;

    acc_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .if_req(if2_req), .if_addr(if2_addr), .if_done(if2_done),
        .dm_req(dm2_req), .dm_we(dm2_we), .dm_addr(dm2_addr), .dm_wdata(dm2_wdata), .dm_done(dm2_done),
        .io_req(io2_req), .io_we(io2_we), .io_addr(io2_addr), .io_wdata(io2_wdata), .io_done(io2_done),
        .rdata(rdata2), .busy(busy2), .grant_id(grant2_id),
        .mem_en(mem2_en), .mem_we(mem2_we), .mem_addr(mem2_addr), .mem_wdata(mem2_wdata),
        .mem_rdata(mem2_rdata)
    );

    // Memory model: unwritten locations return a fixed pattern
    logic [15:0] mem_w [256];
    logic        wr_f  [256];

    function automatic logic [15:0] dflt(input logic [15:0] a);
        if (a == 16'h0010)      return 16'hA5A5;
        else if (a == 16'h0040) return 16'hBEEF;
        else                    return {a[7:0], a[7:0]};
    endfunction

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 256; i++) wr_f[i] <= 1'b0;
        end else if (mem_en && mem_we) begin
            mem_w[mem_addr[7:0]] <= mem_wdata;
            wr_f[mem_addr[7:0]]  <= 1'b1;
        end
    end

    assign mem_rdata  = wr_f[mem_addr[7:0]] ? mem_w[mem_addr[7:0]] : dflt(mem_addr);
    assign mem2_rdata = dflt(mem2_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] id, input logic [15:0] d, input int c);
        exp_t e;
        e.id = id; e.data = d; e.cyc = c;
        return e;
    endfunction

    // Monitor for the main instance
    always @(negedge clk) begin
        int         nd;
        logic [1:0] id;
        exp_t       e;
        nd = int'(if_done) + int'(dm_done) + int'(io_done);
        if (nd > 1) begin
            chk("one_done", nd, 1);
        end else if (nd == 1) begin
            id = if_done ? 2'd1 : (dm_done ? 2'd2 : 2'd3);
            if (q1.size() == 0) begin
                chk("unexpected_done", {30'd0, id}, 0);
            end else begin
                e = q1.pop_front();
                chk("done_id", {30'd0, id}, {30'd0, e.id});
                chk("done_rdata", {16'd0, rdata}, {16'd0, e.data});
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Monitor for the zero-wait instance
    always @(negedge clk) begin
        int         nd2;
        logic [1:0] id2;
        exp_t       e2;
        nd2 = int'(if2_done) + int'(dm2_done) + int'(io2_done);
        if (nd2 > 1) begin
            chk("w0_one_done", nd2, 1);
        end else if (nd2 == 1) begin
            id2 = if2_done ? 2'd1 : (dm2_done ? 2'd2 : 2'd3);
            if (q2.size() == 0) begin
                chk("w0_unexpected_done", {30'd0, id2}, 0);
            end else begin
                e2 = q2.pop_front();
                chk("w0_done_id", {30'd0, id2}, {30'd0, e2.id});
                chk("w0_done_rdata", {16'd0, rdata2}, {16'd0, e2.data});
                chk("w0_done_cycle", cyc, e2.cyc);
            end
        end
    end

    // Run cycles until every raised request has completed; check memory strobes.
    task automatic serve(input string tag, input int exp_en, input int exp_we);
        int en = 0;
        int we = 0;
        int bad_dp = 0;
        int k = 0;
        while ((if_req || dm_req || io_req) && k < 60) begin
            @(negedge clk);
            k++;
            if (mem_en) begin
                en++;
                if (mem_we) we++;
                case (grant_id)
                    2'd1: if (mem_addr !== if_addr || mem_we !== 1'b0) bad_dp++;
                    2'd2: if (mem_addr !== dm_addr || mem_we !== dm_we ||
                              (dm_we && mem_wdata !== dm_wdata)) bad_dp++;
                    2'd3: if (mem_addr !== io_addr || mem_we !== io_we ||
                              (io_we && mem_wdata !== io_wdata)) bad_dp++;
                    default: bad_dp++;
                endcase
            end
            if (if_done) if_req = 1'b0;
            if (dm_done) dm_req = 1'b0;
            if (io_done) io_req = 1'b0;
        end
        chk({tag, "_timeout"}, {29'd0, if_req, dm_req, io_req}, 0);
        chk({tag, "_en_cycles"}, en, exp_en);
        chk({tag, "_we_cycles"}, we, exp_we);
        chk({tag, "_datapath"}, bad_dp, 0);
        @(negedge clk);
        chk({tag, "_grant_idle"}, {30'd0, grant_id}, 0);
        chk({tag, "_busy_idle"}, {31'd0, busy}, 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic all_three(input string tag);
        int c;
        @(negedge clk);
        c = cyc;
        if_addr = 16'h0030;
        dm_addr = 16'h0031; dm_we = 1'b0;
        io_addr = 16'h0032; io_we = 1'b0;
        if_req = 1'b1; dm_req = 1'b1; io_req = 1'b1;
`ifdef ACC_ARB_ROUND_ROBIN_EN
        q1.push_back(mk(2'd1, 16'h3030, c + 4));
        q1.push_back(mk(2'd2, 16'h3131, c + 9));
`else
        q1.push_back(mk(2'd2, 16'h3131, c + 4));
        q1.push_back(mk(2'd1, 16'h3030, c + 9));
`endif
        q1.push_back(mk(2'd3, 16'h3232, c + 14));
        serve(tag, 9, 0);
    endtask

    initial begin
        int c;
        int en2;
        int k;
        reset = 1'b1; tb_init = 1'b1;
        if_req = 0; dm_req = 0; dm_we = 0; io_req = 0; io_we = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0; io_addr = 0; io_wdata = 0;
        if2_req = 0; dm2_req = 0; dm2_we = 0; io2_req = 0; io2_we = 0;
        if2_addr = 0; dm2_addr = 0; dm2_wdata = 0; io2_addr = 0; io2_wdata = 0;
        repeat (3) @(negedge clk);
        tb_init = 1'b0;

        // Reset state
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_grant", {30'd0, grant_id}, 0);
        chk("rst_mem_en", {31'd0, mem_en}, 0);
        chk("rst_mem_we", {31'd0, mem_we}, 0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 0);
        chk("rst_mem_wdata", {16'd0, mem_wdata}, 0);
        chk("rst_rdata", {16'd0, rdata}, 0);
        chk("rst_done", {29'd0, if_done, dm_done, io_done}, 0);
        reset = 1'b0;

        // Fetch read
        @(negedge clk);
        c = cyc;
        if_addr = 16'h0010; if_req = 1'b1;
        q1.push_back(mk(2'd1, 16'hA5A5, c + 4));
        serve("t1_fetch", 3, 0);

        // Store leaves rdata unchanged
        @(negedge clk);
        c = cyc;
        dm_addr = 16'h0020; dm_wdata = 16'h1234; dm_we = 1'b1; dm_req = 1'b1;
        q1.push_back(mk(2'd2, 16'hA5A5, c + 4));
        serve("t2_store", 3, 3);

        // Load back the stored word
        @(negedge clk);
        c = cyc;
        dm_we = 1'b0; dm_wdata = 16'h0000; dm_req = 1'b1;
        q1.push_back(mk(2'd2, 16'h1234, c + 4));
        serve("t2_load", 3, 0);

        // Three simultaneous requesters, twice, starting from reset
        pulse_reset();
        all_three("t3_round1");
        all_three("t3_round2");

        // Reset in the second ACCESS cycle of a load
        @(negedge clk);
        dm_addr = 16'h0020; dm_we = 1'b0; dm_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t5_busy_before", {31'd0, busy}, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_busy", {31'd0, busy}, 0);
        chk("t5_mem_en", {31'd0, mem_en}, 0);
        chk("t5_rdata", {16'd0, rdata}, 0);
        chk("t5_grant", {30'd0, grant_id}, 0);
        reset = 1'b0; dm_req = 1'b0;
        repeat (8) @(negedge clk);
        chk("t5_no_pending", q1.size(), 0);

        // Zero wait states, io read
        @(negedge clk);
        c = cyc;
        io2_addr = 16'h0040; io2_we = 1'b0; io2_req = 1'b1;
        q2.push_back(mk(2'd3, 16'hBEEF, c + 2));
        en2 = 0; k = 0;
        while (io2_req && k < 20) begin
            @(negedge clk);
            k++;
            if (mem2_en) en2++;
            if (io2_done) io2_req = 1'b0;
        end
        chk("t6_timeout", {31'd0, io2_req}, 0);
        chk("t6_en_cycles", en2, 1);
        @(negedge clk);
        chk("t6_busy_idle", {31'd0, busy2}, 0);

        repeat (4) @(negedge clk);
        chk("final_q1_empty", q1.size(), 0);
        chk("final_q2_empty", q2.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
